i2c_txn_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of the I2C master inside `top_module_system`. It accepts whole-transaction commands and buffers write bytes in a small FIFO. It then drives the master's start/stop/direction/address/data inputs byte by byte, and returns read bytes and completion/error status to the host side. The master itself, the slave, and the bus pins are out of scope.

---
 rtl/i2c_txn_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// rtl/i2c_txn_sequencer.sv - whole-transaction sequencer feeding an I2C master
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake; cmd_addr_i, cmd_rnw_i, cmd_len_i
//   wr_valid_i / wr_ready_o    write-byte push into the FIFO; wr_data_i
//   rd_valid_o, rd_data_o      received byte pulse and data
//   done_o, err_o              completion / failure pulses
//   mst_start_o, mst_stop_o, mst_rnw_o, mst_addr_o, mst_wdata_o   master controls
//   mst_rdata_i, mst_busy_i, mst_error_i, mst_byte_done_i         master status
module i2c_txn_sequencer #(
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 3,
    parameter int TO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [6:0]       cmd_addr_i,
    input  logic             cmd_rnw_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [7:0]       wr_data_i,
    output logic             rd_valid_o,
    output logic [7:0]       rd_data_o,
    output logic             done_o,
    output logic             err_o,
    output logic             mst_start_o,
    output logic             mst_stop_o,
    output logic             mst_rnw_o,
    output logic [6:0]       mst_addr_o,
    output logic [7:0]       mst_wdata_o,
    input  logic [7:0]       mst_rdata_i,
    input  logic             mst_busy_i,
    input  logic             mst_error_i,
    input  logic             mst_byte_done_i
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_L    = TO_W'(TO_CYC);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, FLUSH} state_t;

    state_t             state, state_n;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   remaining, remaining_n;
    logic [6:0]         addr_q;
    logic               rnw_q;
    logic [TO_W-1:0]    to_cnt;
    logic               busy_seen;
    logic               idle_q;
    logic               start_q, stop_q, done_q, err_q, rd_valid_q;
    logic [7:0]         rd_data_q;

    logic len_legal, accept, full, push_en, pop, flush;
    logic done_n, err_n, rd_valid_n, timeout;

    // Illegal lengths bypass FIFO gating so they are accepted and rejected
    // instead of stalling forever.
    assign len_legal   = (cmd_len_i != '0) && (cmd_len_i <= DEPTH_L);
    assign cmd_ready_o = idle_q && (!len_legal || cmd_rnw_i || (count >= cmd_len_i));
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign full        = (count == DEPTH_L);
    assign wr_ready_o  = !full;
    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign push_en     = wr_valid_i && (!full || pop);
    assign timeout     = !busy_seen && !mst_busy_i && (to_cnt == TO_L);

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign mst_start_o = start_q;
    assign mst_stop_o  = stop_q;
    assign mst_rnw_o   = rnw_q;
    assign mst_addr_o  = addr_q;
    assign mst_wdata_o = mem[rd_ptr];

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        pop         = 1'b0;
        flush       = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        rd_valid_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!len_legal) begin
                        err_n = 1'b1;
                    end else begin
                        state_n     = START;
                        remaining_n = cmd_len_i;
                    end
                end
            end
            START: begin
                if (mst_error_i || timeout) begin
                    state_n = FLUSH;
                    flush   = !rnw_q;
                end else if (mst_byte_done_i) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (mst_error_i) begin
                    state_n = FLUSH;
                    flush   = !rnw_q;
                end else if (mst_byte_done_i) begin
                    remaining_n = remaining - LEN_W'(1);
                    pop         = !rnw_q;
                    rd_valid_n  = rnw_q;
                    if (remaining == LEN_W'(1)) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (!mst_busy_i) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            FLUSH: begin
                if (!mst_busy_i) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            idle_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            to_cnt     <= '0;
            busy_seen  <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            idle_q     <= (state_n == IDLE);
            start_q    <= (state_n == START);
            // Stop is requested during the final byte and held through STOP/FLUSH.
            stop_q     <= (state_n == STOP) || (state_n == FLUSH) ||
                          ((state_n == DATA) && (remaining_n == LEN_W'(1)));
            done_q     <= done_n;
            err_q      <= err_n;
            rd_valid_q <= rd_valid_n;
            if (rd_valid_n) begin
                rd_data_q <= mst_rdata_i;
            end

            if (accept && len_legal) begin
                addr_q    <= cmd_addr_i;
                rnw_q     <= cmd_rnw_i;
                to_cnt    <= '0;
                busy_seen <= 1'b0;
            end else if (state == START) begin
                if (mst_busy_i) begin
                    busy_seen <= 1'b1;
                end
                if (!busy_seen && (to_cnt != TO_L)) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end

            if (push_en) begin
                mem[wr_ptr] <= wr_data_i;
            end
            wr_ptr <= wr_ptr + PTR_W'(push_en);
            // Flush drops the untransmitted tail of the aborted write in one step.
            rd_ptr <= rd_ptr + PTR_W'(pop) + (flush ? remaining[PTR_W-1:0] : '0);
            count  <= count + LEN_W'(push_en) - LEN_W'(pop) - (flush ? remaining : '0);
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb/tb_i2c_txn_sequencer.sv - self-checking bench for i2c_txn_sequencer
module tb_i2c_txn_sequencer;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_rnw;
    logic [6:0] cmd_addr;
    logic [2:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, done, err;
    logic [7:0] rd_data;
    logic       mst_start, mst_stop, mst_rnw;
    logic [6:0] mst_addr;
    logic [7:0] mst_wdata, mst_rdata;
    logic       mst_busy, mst_error, mst_byte_done;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_rd   = 0;
    int mcount = 0;
    int d0, e0, r0;
    logic [7:0] exp_wq[$];
    logic [7:0] exp_rq[$];
    logic [7:0] rd_bytes[4];

    i2c_txn_sequencer #(.DEPTH(4), .LEN_W(3), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
        .cmd_rnw_i(cmd_rnw), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .done_o(done), .err_o(err),
        .mst_start_o(mst_start), .mst_stop_o(mst_stop), .mst_rnw_o(mst_rnw),
        .mst_addr_o(mst_addr), .mst_wdata_o(mst_wdata), .mst_rdata_i(mst_rdata),
        .mst_busy_i(mst_busy), .mst_error_i(mst_error), .mst_byte_done_i(mst_byte_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) n_done++;
        if (err) n_err++;
        if (rd_valid) begin
            n_rd++;
            chk("rd_pending", 32'(exp_rq.size() != 0), 1);
            if (exp_rq.size() != 0) chk("rd_data", rd_data, exp_rq.pop_front());
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        if (mcount < 4) begin
            exp_wq.push_back(d);
            mcount++;
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic r, input logic [2:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rnw   = r;
        cmd_len   = l;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_ready) break;
            tick();
        end
        chk("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b1;
        cmd_len   = 3'd1;
    endtask

    // Master model; entered right after the command handshake edge.
    task automatic master(input int nb, input logic rd, input logic [6:0] a,
                          input int nack_at, input int push_at, input logic [7:0] push_d);
        chk("start_hi", mst_start, 1);
        chk("mst_addr", mst_addr, a);
        chk("mst_rnw", mst_rnw, rd);
        mst_busy = 1'b1;
        tick();
        tick();
        chk("start_held", mst_start, 1);
        mst_byte_done = 1'b1;
        tick();
        mst_byte_done = 1'b0;
        chk("start_drop", mst_start, 0);
        for (int i = 0; i < nb; i++) begin
            if (i == nack_at) begin
                mst_error = 1'b1;
                tick();
                mst_error = 1'b0;
                chk("nack_start", mst_start, 0);
                chk("nack_stop", mst_stop, 1);
                if (!rd) begin
                    for (int k = i; k < nb; k++) begin
                        void'(exp_wq.pop_front());
                        mcount--;
                    end
                end
                tick();
                tick();
                chk("nack_stop_held", mst_stop, 1);
                mst_busy = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (err) break;
                end
                chk("nack_err", err, 1);
                chk("nack_stop_rel", mst_stop, 0);
                return;
            end
            tick();
            chk("stop_req", mst_stop, 32'(i == nb - 1));
            if (!rd) begin
                chk("wdata", mst_wdata, exp_wq[0]);
                void'(exp_wq.pop_front());
                mcount--;
            end else begin
                mst_rdata = rd_bytes[i];
                exp_rq.push_back(rd_bytes[i]);
            end
            mst_byte_done = 1'b1;
            if (i == push_at) begin
                wr_valid = 1'b1;
                wr_data  = push_d;
                exp_wq.push_back(push_d);
                mcount++;
            end
            tick();
            mst_byte_done = 1'b0;
            wr_valid = 1'b0;
            mst_rdata = 8'h00;
            if (i == push_at) chk("pushpop_full", wr_ready, 32'(mcount < 4));
        end
        chk("stop_last", mst_stop, 1);
        tick();
        tick();
        chk("stop_held", mst_stop, 1);
        mst_busy = 1'b0;
        tick();
        chk("done_pulse", done, 1);
        chk("stop_rel", mst_stop, 0);
        chk("ready_after", cmd_ready, 1);
        tick();
        chk("done_once", done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_rnw = 1'b1; cmd_len = 3'd1;
        wr_valid = 1'b0; wr_data = '0;
        mst_rdata = '0; mst_busy = 1'b0; mst_error = 1'b0; mst_byte_done = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_outs", {mst_start, mst_stop, done, err, rd_valid}, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready, 1);

        // Write 0xCC, 0x92 to 0x57
        push(8'hCC);
        push(8'h92);
        d0 = n_done; e0 = n_err;
        send_cmd(7'h57, 1'b0, 3'd2);
        master(2, 1'b0, 7'h57, -1, -1, 8'h00);
        chk("w_done_cnt", n_done - d0, 1);
        chk("w_err_cnt", n_err - e0, 0);
        cmd_rnw = 1'b0; #1;
        chk("w_fifo_empty", cmd_ready, 0);
        cmd_rnw = 1'b1;

        // Read 2 bytes from 0x57
        rd_bytes[0] = 8'hAD; rd_bytes[1] = 8'h0B;
        d0 = n_done; e0 = n_err; r0 = n_rd;
        send_cmd(7'h57, 1'b1, 3'd2);
        master(2, 1'b1, 7'h57, -1, -1, 8'h00);
        chk("r_rd_cnt", n_rd - r0, 2);
        chk("r_done_cnt", n_done - d0, 1);
        chk("r_err_cnt", n_err - e0, 0);

        // NACK after the address byte
        push(8'h11);
        push(8'h22);
        d0 = n_done; e0 = n_err;
        send_cmd(7'h77, 1'b0, 3'd2);
        master(2, 1'b0, 7'h77, 0, -1, 8'h00);
        chk("nack_err_cnt", n_err - e0, 1);
        chk("nack_done_cnt", n_done - d0, 0);
        cmd_rnw = 1'b0; #1;
        chk("nack_fifo_empty", cmd_ready, 0);
        cmd_rnw = 1'b1;

        // FIFO gating and pointer wrap
        for (int rep = 0; rep < 3; rep++) begin
            push(8'(8'h30 + rep * 3));
            push(8'(8'h31 + rep * 3));
            cmd_valid = 1'b1; cmd_addr = 7'h42; cmd_rnw = 1'b0; cmd_len = 3'd3;
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("gate_ready_lo", cmd_ready, 0);
                tick();
            end
            push(8'(8'h32 + rep * 3));
            d0 = n_done;
            send_cmd(7'h42, 1'b0, 3'd3);
            master(3, 1'b0, 7'h42, -1, -1, 8'h00);
            chk("gate_done", n_done - d0, 1);
        end

        // Push while full, then push+pop while full
        push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
        chk("full_wr_ready", wr_ready, 0);
        push(8'hEE);
        chk("full_still", wr_ready, 0);
        send_cmd(7'h21, 1'b0, 3'd4);
        master(4, 1'b0, 7'h21, -1, 0, 8'hF5);
        chk("after_full_ready", wr_ready, 1);
        send_cmd(7'h21, 1'b0, 3'd1);
        master(1, 1'b0, 7'h21, -1, -1, 8'h00);

        // Illegal lengths
        e0 = n_err;
        send_cmd(7'h12, 1'b0, 3'd0);
        chk("len0_err", err, 1);
        chk("len0_start", mst_start, 0);
        tick();
        chk("len0_err_once", err, 0);
        send_cmd(7'h12, 1'b1, 3'd5);
        chk("len5_err", err, 1);
        chk("len5_start", mst_start, 0);
        tick();
        chk("illegal_err_cnt", n_err - e0, 2);

        // Timeout with busy held low
        d0 = n_done; e0 = n_err;
        send_cmd(7'h10, 1'b1, 3'd1);
        begin
            int k;
            for (k = 1; k <= 300; k++) begin
                tick();
                if (k == 100) chk("to_start_held", mst_start, 1);
                if (err) break;
            end
            chk("to_window", 32'(k >= TO && k <= TO + 4), 1);
        end
        chk("to_err_cnt", n_err - e0, 1);
        chk("to_done_cnt", n_done - d0, 0);
        chk("to_start_low", mst_start, 0);

        // Reset mid-DATA
        push(8'h5A);
        push(8'h6B);
        send_cmd(7'h33, 1'b0, 3'd2);
        mst_busy = 1'b1;
        tick();
        mst_byte_done = 1'b1;
        tick();
        mst_byte_done = 1'b0;
        chk("pre_rst_wdata", mst_wdata, 8'h5A);
        d0 = n_done; e0 = n_err;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {mst_start, mst_stop, done, err, rd_valid, cmd_ready}, 0);
        chk("mid_rst_data", {mst_addr, mst_rnw, mst_wdata, rd_data}, 0);
        chk("mid_rst_wr_ready", wr_ready, 1);
        exp_wq.delete();
        mcount = 0;
        mst_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_pulses", (n_done - d0) + (n_err - e0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
